// File: rtl/mul_sequencer.sv
// mul_sequencer: walks the fixed T0..T6 control steps for one `mul Rb, Rc`
// instruction, producing one-hot bus source selects and register load
// enables. All outputs are decoded from registered state (Moore style).
module mul_sequencer #(
  parameter logic [4:0] MUL_OPCODE = 5'b01111,
  parameter int         NUM_GPR    = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [31:0]        ir,
  input  logic               mem_rdy,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [NUM_GPR-1:0] R_out,
  output logic [NUM_GPR-1:0] R_in,
  output logic               PCout,
  output logic               ZLowOut,
  output logic               ZHighOut,
  output logic               MDRout,
  output logic               HIout,
  output logic               LOout,
  output logic               InPortOut,
  output logic               Cout,
  output logic               PCin,
  output logic               IRin,
  output logic               MARin,
  output logic               MDRin,
  output logic               Yin,
  output logic               Zin,
  output logic               HIin,
  output logic               LOin,
  output logic               IncPC,
  output logic               Read,
  output logic               Mul
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, DONE
  } state_t;

  state_t state, state_next;
  logic   err_q, err_next;

  logic [4:0] opcode;
  logic [3:0] rb_idx;
  logic [3:0] rc_idx;
  logic       unused_ir_bits;

  assign opcode         = ir[31:27];
  assign rb_idx         = ir[22:19];
  assign rc_idx         = ir[18:15];
  assign unused_ir_bits = ^{ir[26:23], ir[14:0]};

  // Indices at or beyond NUM_GPR select nothing rather than wrapping.
  function automatic logic [NUM_GPR-1:0] gpr_select(input logic [3:0] idx);
    gpr_select = '0;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (int'(idx) == i) gpr_select[i] = 1'b1;
    end
  endfunction

  // Sources this block never drives onto the bus, and GPRs it never loads.
  assign R_in      = '0;
  assign HIout     = 1'b0;
  assign LOout     = 1'b0;
  assign InPortOut = 1'b0;
  assign Cout      = 1'b0;

  // State register plus the one-cycle error flag that follows a bad opcode.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      err_q <= err_next;
    end
  end

  // Next-state and control-step decode; every output defaults to inactive.
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = err_q;
    R_out      = '0;
    PCout      = 1'b0;
    ZLowOut    = 1'b0;
    ZHighOut   = 1'b0;
    MDRout     = 1'b0;
    PCin       = 1'b0;
    IRin       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Mul        = 1'b0;

    case (state)
      IDLE: begin
        if (start && !err_q) state_next = T0;
      end
      T0: begin
        busy       = 1'b1;
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zin        = 1'b1;
        state_next = T1;
      end
      T1: begin
        busy    = 1'b1;
        ZLowOut = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_rdy) state_next = T2;
      end
      T2: begin
        busy       = 1'b1;
        MDRout     = 1'b1;
        IRin       = 1'b1;
        state_next = T3;
      end
      T3: begin
        busy = 1'b1;
        if (opcode == MUL_OPCODE) begin
          R_out      = gpr_select(rb_idx);
          Yin        = 1'b1;
          state_next = T4;
        end else begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      T4: begin
        busy       = 1'b1;
        R_out      = gpr_select(rc_idx);
        Mul        = 1'b1;
        Zin        = 1'b1;
        state_next = T5;
      end
      T5: begin
        busy       = 1'b1;
        ZLowOut    = 1'b1;
        LOin       = 1'b1;
        state_next = T6;
      end
      T6: begin
        busy       = 1'b1;
        ZHighOut   = 1'b1;
        HIin       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? T0 : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed plus randomized checks of mul_sequencer against
// an instruction-level model that expands each accepted mul into its
// expected per-cycle control trace.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] ir;
  logic        mem_rdy;
  logic        busy, done, err;
  logic [15:0] R_out, R_in;
  logic        PCout, ZLowOut, ZHighOut, MDRout;
  logic        HIout, LOout, InPortOut, Cout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
  logic        IncPC, Read, Mul;

  mul_sequencer #(.MUL_OPCODE(5'b01111), .NUM_GPR(16)) dut (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_rdy(mem_rdy),
    .busy(busy), .done(done), .err(err),
    .R_out(R_out), .R_in(R_in),
    .PCout(PCout), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortOut(InPortOut), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .Mul(Mul)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy, done, err;
    logic [15:0] r_out;
    logic        pc_out, zlow_out, zhigh_out, mdr_out;
    logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
    logic        inc_pc, read, mul;
  } obs_t;

  localparam int K_IDLE = 0;
  localparam int K_BUSY = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    obs_t o;
    int   kind;
  } exp_t;

  exp_t exp_q[$];
  logic mem_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   start_cyc = -1;
  int   exp_lat = 0;

  obs_t act;
  assign act = {busy, done, err, R_out, PCout, ZLowOut, ZHighOut, MDRout,
                PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
                IncPC, Read, Mul};

  logic [23:0] bus_sel;
  assign bus_sel = {R_out, PCout, ZLowOut, ZHighOut, MDRout,
                    HIout, LOout, InPortOut, Cout};

  task automatic push_exp(input obs_t o, input int kind);
    exp_t e;
    e.o = o;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Expand one accepted instruction (with w memory wait cycles) into the
  // cycles that follow the accepting edge.
  task automatic push_instr(input logic [31:0] iv, input int w);
    obs_t b;
    b = '0; b.busy = 1; b.pc_out = 1; b.mar_in = 1; b.inc_pc = 1; b.z_in = 1;
    push_exp(b, K_BUSY);
    mem_q.push_back(1'($urandom));
    b = '0; b.busy = 1; b.zlow_out = 1; b.pc_in = 1; b.read = 1; b.mdr_in = 1;
    for (int i = 0; i <= w; i++) begin
      push_exp(b, K_BUSY);
      mem_q.push_back(i == w);
    end
    b = '0; b.busy = 1; b.mdr_out = 1; b.ir_in = 1;
    push_exp(b, K_BUSY);
    if (iv[31:27] == 5'b01111) begin
      b = '0; b.busy = 1; b.r_out = 16'(1) << iv[22:19]; b.y_in = 1;
      push_exp(b, K_BUSY);
      b = '0; b.busy = 1; b.r_out = 16'(1) << iv[18:15]; b.mul = 1; b.z_in = 1;
      push_exp(b, K_BUSY);
      b = '0; b.busy = 1; b.zlow_out = 1; b.lo_in = 1;
      push_exp(b, K_BUSY);
      b = '0; b.busy = 1; b.zhigh_out = 1; b.hi_in = 1;
      push_exp(b, K_BUSY);
      b = '0; b.done = 1;
      push_exp(b, K_DONE);
    end else begin
      b = '0; b.busy = 1;
      push_exp(b, K_BUSY);
      b = '0; b.err = 1;
      push_exp(b, K_ERR);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    n_cmp++;
    assert (act === e.o) else begin
      n_bad++;
      $error("[TB] FAIL outputs cyc=%0d got=%h exp=%h", cyc, act, e.o);
    end
    n_cmp++;
    assert (!$isunknown(bus_sel) && $countones(bus_sel) <= 1) else begin
      n_bad++;
      $error("[TB] FAIL onehot cyc=%0d got=%h exp=at most one bit", cyc, bus_sel);
    end
    n_cmp++;
    assert ({R_in, HIout, LOout, InPortOut, Cout} === 20'h0) else begin
      n_bad++;
      $error("[TB] FAIL unused_zero cyc=%0d got=%h exp=0", cyc,
             {R_in, HIout, LOout, InPortOut, Cout});
    end
    if (done === 1'b1) begin
      n_cmp++;
      assert (cyc - start_cyc === exp_lat) else begin
        n_bad++;
        $error("[TB] FAIL latency cyc=%0d got=%0d exp=%0d", cyc,
               cyc - start_cyc, exp_lat);
      end
    end
  endtask

  // One clock cycle: drive inputs, check this cycle's outputs, update model.
  task automatic applyStimulus(input logic s, input logic c,
                               input logic [31:0] new_ir, input int w);
    exp_t cur;
    logic acc;
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else begin
      cur.o = '0;
      cur.kind = K_IDLE;
    end
    start = s;
    clr   = c;
    if (mem_q.size() > 0) mem_rdy = mem_q.pop_front();
    else mem_rdy = 1'($urandom);
    acc = s && !c && (cur.kind == K_IDLE || cur.kind == K_DONE);
    if (acc) ir = new_ir;
    @(negedge clk);
    checkOutput(cur);
    if (c) begin
      exp_q.delete();
      mem_q.delete();
      start_cyc = -1;
    end else if (acc) begin
      push_instr(new_ir, w);
      start_cyc = cyc;
      exp_lat = 8 + w;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 0);
  endtask

  logic [31:0] rir;

  initial begin
    clr = 1'b1; start = 1'b0; ir = 32'h0; mem_rdy = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset with start held");
    applyStimulus(1'b1, 1'b1, 32'h799A0000, 0);
    applyStimulus(1'b1, 1'b1, 32'h799A0000, 0);
    idle(3);

    $display("[TB] mul r3,r4 with memory ready");
    applyStimulus(1'b1, 1'b0, 32'h799A0000, 0);
    idle(10);

    $display("[TB] mul r3,r4 with three wait cycles");
    applyStimulus(1'b1, 1'b0, 32'h799A0000, 3);
    idle(13);

    $display("[TB] bad opcode");
    applyStimulus(1'b1, 1'b0, 32'h18000000, 0);
    idle(4);
    applyStimulus(1'b1, 1'b0, 32'h18000000, 0);
    idle(3);
    applyStimulus(1'b1, 1'b0, 32'h18000000, 0);
    applyStimulus(1'b1, 1'b0, 32'h799A0000, 0);
    idle(10);

    $display("[TB] reset during T4, then clean rerun");
    applyStimulus(1'b1, 1'b0, 32'h799A0000, 0);
    idle(4);
    applyStimulus(1'b0, 1'b1, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 32'h78000000 | (7 << 19) | (7 << 15), 1);
    idle(11);

    $display("[TB] start held for back-to-back instructions");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 32'h799A0000, 0);
    idle(10);
    applyStimulus(1'b1, 1'b0, 32'h799A0000, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 32'h799A0000, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 32'h799A0000, 0);
    idle(8);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) rir = {5'b01111, 27'($urandom)};
      else rir = $urandom;
      applyStimulus(1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 49) == 0),
                    rir, int'($urandom_range(0, 3)));
    end
    idle(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Control-step sequencer that drives the bus-side controls for one `mul Rb, Rc` instruction. It produces the one-hot bus source selects consumed by the bus 32-to-5 encoder, and the register load enables (PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, R_in). It runs the fixed step sequence T0..T6, which covers fetch, decode of Rb/Rc from IR, multiply into Z, then ZLow→LO and ZHigh→HI. It is the initiator counterpart to the bus/register datapath, and replaces hand-driven out/enable waveforms in benches.

Parameters:
MUL_OPCODE, 5'b01111, opcode value in ir[31:27] accepted as mul
NUM_GPR, 16, number of general registers; width of R_out and R_in

Ports:
clk  in  1  clock; all state changes on rising edge
clr  in  1  reset, synchronous, active-high; sampled on rising edge of clk
start  in  1  request one mul instruction; sampled only in IDLE
ir  in  32  current IR contents; opcode [31:27], Rb [22:19], Rc [18:15]
mem_rdy  in  1  memory read data valid during T1
busy  out  1  high from T0 through T6
done  out  1  one-cycle pulse after T6 completes
err  out  1  one-cycle pulse when opcode at T3 is not MUL_OPCODE
R_out  out  NUM_GPR  one-hot GPR bus-source select
R_in  out  NUM_GPR  GPR load enables; always 0 in this block
PCout, ZLowOut, ZHighOut, MDRout  out  1 each  bus-source selects
HIout, LOout, InPortOut, Cout  out  1 each  bus-source selects; always 0 in this block
PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin  out  1 each  register load enables
IncPC, Read, Mul  out  1 each  ALU increment, memory read, ALU multiply select

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE.
- All outputs are Moore-style, decoded from the registered state plus the Rb/Rc index fields. No output depends combinationally on start or mem_rdy.
- Reset: clr=1 at a rising edge forces IDLE. All outputs are 0 in the following cycle.
  - This applies in any state, including mid-sequence and during a T1 wait.
  - No partial step completes after reset.
- IDLE: start=1 → T0; otherwise stay in IDLE.
- T0: PCout, MARin, IncPC, Zin. Unconditionally → T1.
- T1: ZLowOut, PCin, Read, MDRin.
  - Hold T1 with identical outputs while mem_rdy=0.
  - mem_rdy=1 → T2. Minimum one cycle in T1.
- T2: MDRout, IRin. → T3.
- T3: ir[31:27] is checked.
  - If it is not MUL_OPCODE: no outputs asserted in that cycle, err pulses the next cycle, return to IDLE. busy drops with the err pulse.
  - Otherwise: R_out[ir[22:19]]=1, Yin. → T4.
- T4: R_out[ir[18:15]]=1, Mul, Zin. → T5.
- T5: ZLowOut, LOin. → T6.
- T6: ZHighOut, HIin. → DONE.
- DONE: done=1, busy=0, no other outputs asserted. → T0 if start=1, else → IDLE.
- One-hot bus rule: in every cycle at most one of R_out bits, PCout, ZLowOut, ZHighOut, MDRout, HIout, LOout, InPortOut, Cout is 1. A bench assertion checks this every cycle.
- Index fields: Rb/Rc are sampled from ir in the cycle they are used. ir must stay stable from T3 to T4; the IR register guarantees this. An index of NUM_GPR or more asserts no R_out bit.
- Rb == Rc is legal: the same R_out bit is asserted in T3 and T4.
- start while busy or in err cycle: ignored, not queued.
- Latency with mem_rdy already high: start sampled at edge k → T0 in cycle k+1 → done=1 in cycle k+8. Each mem_rdy wait cycle adds one.

Test Plan:
1. clr held 2 cycles with start=1 → all outputs 0, state IDLE; release clr with start=0 → remains IDLE, busy=0.
2. ir=0x799A0000 (op 01111, Rb=3, Rc=4), start one cycle, mem_rdy=1 → expected output sequence:
   - T0: PCout, MARin, IncPC, Zin
   - T1: ZLowOut, PCin, Read, MDRin
   - T2: MDRout, IRin
   - T3: R_out=0x0008, Yin
   - T4: R_out=0x0010, Mul, Zin
   - T5: ZLowOut, LOin
   - T6: ZHighOut, HIin
   - done pulses 8 cycles after start, one-hot rule holds every cycle.
3. Same ir, mem_rdy=0 for 3 cycles in T1 → T1 outputs held 4 cycles, done 11 cycles after start, PCin high all 4 cycles.
4. ir=0x18000000 (op 00011) → T0–T2 normal, no selects in T3, err=1 one cycle, then IDLE, no Yin/Zin/HIin/LOin.
5. clr=1 during T4 → next cycle all outputs 0, IDLE. A subsequent start runs a full clean sequence from T0.
6. start held high continuously → DONE goes directly to T0; two back-to-back instructions with done pulses 8 cycles apart. start pulses during busy have no effect.
